// File: rtl/payment_terminal.sv
// Card-side responder for the wash-bay POS: latches a selection, waits for a card read,
// debits the card and holds the approval/decline result. Optional REVENUE_LOG_EN adds txn_count/revenue.
module payment_terminal #(
   parameter int BAL_W        = 16,
   parameter int PRICE_BASIC  = 5,
   parameter int PRICE_PLUS   = 8,
   parameter int PRICE_DETAIL = 12,
   parameter int CARD_TIMEOUT = 1000,
   parameter int HOLD_CYCLES  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       selection,
   input  logic             req,
   input  logic             cancel,
   input  logic             card_valid,
   input  logic [BAL_W-1:0] card_balance,
   output logic             approval_status,
   output logic             busy,
   output logic [1:0]       decline_code,
   output logic             write_card,
   output logic [BAL_W-1:0] new_balance,
   output logic             done
`ifdef REVENUE_LOG_EN
   ,
   output logic [15:0]      txn_count,
   output logic [BAL_W+7:0] revenue
`endif
);

   typedef enum logic [2:0] {IDLE, WAIT_CARD, CHECK, APPROVE, DECLINE} state_t;

   localparam int TMO_W  = $clog2(CARD_TIMEOUT + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(CARD_TIMEOUT);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t             state_q, state_d;
   logic [BAL_W-1:0]   price_q, price_d;
   logic [BAL_W-1:0]   bal_q, bal_d;
   logic [BAL_W-1:0]   nb_q, nb_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [1:0]         code_q, code_d;

   function automatic logic [BAL_W-1:0] price_of(input logic [1:0] sel);
      case (sel)
         2'b01:   price_of = BAL_W'(PRICE_BASIC);
         2'b10:   price_of = BAL_W'(PRICE_PLUS);
         2'b11:   price_of = BAL_W'(PRICE_DETAIL);
         default: price_of = '0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         price_q <= '0;
         bal_q   <= '0;
         nb_q    <= '0;
         tmo_q   <= '0;
         hold_q  <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         price_q <= price_d;
         bal_q   <= bal_d;
         nb_q    <= nb_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      price_d         = price_q;
      bal_d           = bal_q;
      nb_d            = nb_q;
      tmo_d           = tmo_q;
      hold_d          = hold_q;
      code_d          = code_q;
      approval_status = 1'b0;
      busy            = 1'b0;
      decline_code    = 2'd0;
      write_card      = 1'b0;
      done            = 1'b0;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            code_d = 2'd0;
            if (req && selection != 2'b00) begin
               price_d = price_of(selection);
               tmo_d   = TMO_LOAD;
               state_d = WAIT_CARD;
            end
         end
         WAIT_CARD: begin
            busy = 1'b1;
            // cancel beats a card read, and a card read beats the timeout
            if (cancel) begin
               code_d  = 2'd3;
               state_d = DECLINE;
            end else if (card_valid) begin
               bal_d   = card_balance;
               state_d = CHECK;
            end else if (tmo_q == TMO_W'(1)) begin
               code_d  = 2'd1;
               state_d = DECLINE;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         CHECK: begin
            busy = 1'b1;
            if (bal_q >= price_q) begin
               nb_d    = bal_q - price_q;
               state_d = APPROVE;
            end else begin
               code_d  = 2'd2;
               state_d = DECLINE;
            end
         end
         APPROVE: begin
            busy            = 1'b1;
            approval_status = 1'b1;
            write_card      = (hold_q == '0);
            if (hold_q == HOLD_LAST) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         DECLINE: begin
            busy         = 1'b1;
            decline_code = code_q;
            if (hold_q == HOLD_LAST) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign new_balance = nb_q;

`ifdef REVENUE_LOG_EN
   logic [15:0]      txn_q, txn_d;
   logic [BAL_W+7:0] rev_q, rev_d;
   logic [BAL_W+8:0] rev_sum;

   // both counters saturate rather than wrap
   always_comb begin
      txn_d   = txn_q;
      rev_d   = rev_q;
      rev_sum = {1'b0, rev_q} + {9'b0, price_q};
      if (write_card) begin
         if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
         rev_d = rev_sum[BAL_W+8] ? '1 : rev_sum[BAL_W+7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txn_q <= '0;
         rev_q <= '0;
      end else begin
         txn_q <= txn_d;
         rev_q <= rev_d;
      end
   end

   assign txn_count = txn_q;
   assign revenue   = rev_q;
`endif

endmodule

// File: tb/tb_payment_terminal.sv
// Scoreboard bench for payment_terminal: expected outcomes are queued when a transaction
// is driven and compared when done fires.
module tb_payment_terminal;
   localparam int BAL_W = 16;
   localparam int T     = 10;
   localparam int HOLD  = 4;
   localparam int NONE  = 1 << 30;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       selection;
   logic             req, cancel, card_valid;
   logic [BAL_W-1:0] card_balance;
   logic             approval_status, busy, write_card, done;
   logic [1:0]       decline_code;
   logic [BAL_W-1:0] new_balance;
`ifdef REVENUE_LOG_EN
   logic [15:0]      txn_count;
   logic [BAL_W+7:0] revenue;
`endif

   typedef struct packed {
      logic        appr;
      logic [1:0]  code;
      logic [15:0] nb;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0;
   int          wr_cnt = 0, hold_cnt = 0, done_cnt = 0;
   int          appr_cyc = 0, dec_cyc = 0;
   logic        prev_appr = 1'b0, prev_dec = 1'b0;
   logic [15:0] model_nb = '0;
   int          exp_txn = 0, exp_rev = 0;

   payment_terminal #(.CARD_TIMEOUT(T), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .reset(reset), .selection(selection), .req(req), .cancel(cancel),
      .card_valid(card_valid), .card_balance(card_balance),
      .approval_status(approval_status), .busy(busy), .decline_code(decline_code),
      .write_card(write_card), .new_balance(new_balance), .done(done)
`ifdef REVENUE_LOG_EN
      , .txn_count(txn_count), .revenue(revenue)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int price_of(input logic [1:0] sel);
      case (sel)
         2'd1:    return 5;
         2'd2:    return 8;
         2'd3:    return 12;
         default: return 0;
      endcase
   endfunction

   // output monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (write_card) wr_cnt++;
      if (approval_status || decline_code != 2'd0) hold_cnt++;
      if (approval_status && !prev_appr) begin
         appr_cyc = cyc;
         check_eq("write_first_cycle", write_card, 1);
      end
      if (decline_code != 2'd0 && !prev_dec) dec_cyc = cyc;
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) check_eq("unexpected_done", done, 0);
         else begin
            mon_e = sb.pop_front();
            check_eq("approval", approval_status, mon_e.appr);
            check_eq("decline_code", decline_code, mon_e.code);
            check_eq("new_balance", new_balance, mon_e.nb);
            check_eq("write_count", wr_cnt, mon_e.appr ? 1 : 0);
            check_eq("hold_cycles", hold_cnt, HOLD);
         end
         wr_cnt   = 0;
         hold_cnt = 0;
      end
      prev_appr = approval_status;
      prev_dec  = (decline_code != 2'd0);
   end

   // card_at / cancel_at: WAIT_CARD cycle index of the strobe, negative for none
   task automatic run_txn(input logic [1:0] sel, input logic [15:0] bal,
                          input int card_at, input int cancel_at);
      exp_t e;
      int   first;
      int   wait_cyc = 0, card_cyc = 0;
      logic card_win = 1'b0;
      int   cw = (card_at >= 0 && card_at < T) ? card_at : NONE;
      int   cn = (cancel_at >= 0 && cancel_at < T) ? cancel_at : NONE;
      if (cn != NONE && cn <= cw) begin
         e = '{1'b0, 2'd3, model_nb};
         first = cn;
      end else if (cw != NONE) begin
         card_win = 1'b1;
         first = cw;
         if (int'(bal) >= price_of(sel)) begin
            model_nb = bal - 16'(price_of(sel));
            e = '{1'b1, 2'd0, model_nb};
            exp_txn++;
            exp_rev += price_of(sel);
         end else begin
            e = '{1'b0, 2'd2, model_nb};
         end
      end else begin
         e = '{1'b0, 2'd1, model_nb};
         first = T - 1;
      end
      sb.push_back(e);

      @(posedge clk); #1;
      req = 1'b1; selection = sel;
      @(posedge clk); #1;
      req = 1'b0; selection = ~sel;
      wait_cyc = cyc;
      for (int i = 0; i <= first; i++) begin
         card_valid   = (i == card_at);
         cancel       = (i == cancel_at);
         card_balance = (i == card_at) ? bal : 16'hFFFF;
         if (i == card_at) card_cyc = cyc;
         @(posedge clk); #1;
      end
      card_valid = 1'b0;
      cancel     = 1'b0;
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
      check_eq("scoreboard_drain", sb.size(), 0);
      sb.delete();
      if (card_win && e.appr) check_eq("approve_latency", appr_cyc - card_cyc, 2);
      if (e.code == 2'd1) check_eq("timeout_latency", dec_cyc - wait_cyc, T);
   endtask

   initial begin
      int d0;
      reset = 1'b1; selection = 2'd0; req = 1'b0; cancel = 1'b0;
      card_valid = 1'b0; card_balance = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_approval", approval_status, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_code", decline_code, 0);
      check_eq("rst_write", write_card, 0);
      check_eq("rst_new_balance", new_balance, 0);
      check_eq("rst_done", done, 0);
      @(negedge clk) reset = 1'b0;

      run_txn(2'd1, 16'd20, 0, -1);
      run_txn(2'd3, 16'd12, 2, -1);
      run_txn(2'd2, 16'd7, 1, -1);
      run_txn(2'd1, 16'd30, -1, -1);
      run_txn(2'd2, 16'd100, T - 1, -1);
      run_txn(2'd3, 16'd50, 3, 3);
      run_txn(2'd1, 16'd50, -1, 2);

      @(posedge clk); #1;
      req = 1'b1; selection = 2'd0;
      @(posedge clk); #1;
      req = 1'b0;
      check_eq("sel0_busy", busy, 0);
      @(posedge clk); #1;
      check_eq("sel0_busy_later", busy, 0);

      for (int r = 0; r < 6; r++) begin
         run_txn(2'($urandom_range(1, 3)), 16'($urandom_range(0, 20)),
                 int'($urandom_range(0, T + 2)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T)) : -1);
      end

      // async reset during the second APPROVE cycle
      @(posedge clk); #1;
      req = 1'b1; selection = 2'd1;
      @(posedge clk); #1;
      req = 1'b0;
      card_valid = 1'b1; card_balance = 16'd20;
      @(posedge clk); #1;
      card_valid = 1'b0;
      for (int k = 0; k < 20 && !approval_status; k++) @(negedge clk);
      check_eq("abort_appr_seen", approval_status, 1);
      d0 = done_cnt;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_eq("abort_approval", approval_status, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_write", write_card, 0);
      check_eq("abort_new_balance", new_balance, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_code", decline_code, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      wr_cnt = 0; hold_cnt = 0;
      model_nb = '0; exp_txn = 0; exp_rev = 0;
      repeat (3) @(posedge clk);
      check_eq("abort_no_done", done_cnt, d0);

      for (int r = 0; r < 3; r++) run_txn(2'd1, 16'd40, 1, -1);
`ifdef REVENUE_LOG_EN
      check_eq("txn_count", txn_count, exp_txn);
      check_eq("revenue", revenue, exp_rev);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/payment_terminal.md
Name: payment_terminal

Overview:
Card-side responder for the wash-bay point-of-sale handshake. It receives a wash selection and an authorization request, waits for a card read, checks the card balance against the selection price, debits the card, and drives the approval level the POS samples. It sits between the card reader front-end and the POS/carwash controller and sources the approval status that feeds the carwash.

Parameters:
BAL_W, 16, width of card balance and price values
PRICE_BASIC, 5, price of selection 2'b01
PRICE_PLUS, 8, price of selection 2'b10
PRICE_DETAIL, 12, price of selection 2'b11
CARD_TIMEOUT, 1000, cycles to wait for card_valid before declining, minimum 1
HOLD_CYCLES, 4, cycles that approval_status or decline_code is held, minimum 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
selection  input  2  wash selection: 0 none, 1 basic, 2 basic plus, 3 detail
req  input  1  authorization request, sampled in IDLE only
cancel  input  1  user cancel, honoured in WAIT_CARD only
card_valid  input  1  single-cycle strobe, card_balance valid
card_balance  input  BAL_W  balance read from card
approval_status  output  1  approval level to the POS
busy  output  1  transaction in progress
decline_code  output  2  0 none, 1 timeout, 2 insufficient funds, 3 cancelled
write_card  output  1  one-cycle strobe to write new_balance back to the card
new_balance  output  BAL_W  debited balance, valid while write_card=1 and held afterwards
done  output  1  one-cycle strobe at end of transaction

Behaviour:
- Reset is asynchronous and active-high. While asserted, state=IDLE and every output is 0, including the latched price, the latched balance and the counters. Reset mid-transaction aborts it with no write_card and no done.
- States: IDLE, WAIT_CARD, CHECK, APPROVE, DECLINE.
- IDLE: busy=0.
  - req=1 with selection!=0: latch selection and its price, load timeout counter with CARD_TIMEOUT, go to WAIT_CARD.
  - req=1 with selection=0: ignored.
- WAIT_CARD: busy=1. Priority order:
  1. cancel -> DECLINE, code 3.
  2. card_valid -> latch card_balance, go to CHECK.
  3. counter==1 -> DECLINE, code 1.
  4. otherwise decrement the counter.
  - card_valid in the same cycle as the timeout: the card wins.
- CHECK: exactly one cycle.
  - latched balance >= price (unsigned): go to APPROVE; new_balance <= balance - price.
  - Balance equal to price is approved, with new_balance=0.
  - Otherwise go to DECLINE, code 2; new_balance unchanged.
- APPROVE: approval_status=1 for exactly HOLD_CYCLES cycles. write_card=1 in the first APPROVE cycle only. done=1 in the last cycle, then go to IDLE.
- DECLINE: approval_status=0; decline_code held for HOLD_CYCLES cycles; done=1 in the last cycle, then go to IDLE.
- decline_code and approval_status clear to 0 on the return to IDLE.
- Latency: card_valid sampled at cycle N -> approval_status=1 from cycle N+2.
- req, selection and card_valid are ignored outside their sampling states. A selection change after latching has no effect.
- No arithmetic wrap: a debit only happens when balance >= price. The hold counter and timeout counter are sized by $clog2 of their parameters.

Optional Feature:
REVENUE_LOG_EN
- Defined: adds two outputs.
  - txn_count (16 bits): increments on each write_card.
  - revenue (BAL_W+8 bits): accumulates the price on each write_card.
  - Both saturate at their maximum value and are cleared by reset only.
- Undefined: neither port nor the logic exists; all other behaviour is identical.

Test Plan:
- Basic approve: req, selection=1, card_valid with balance=20 -> write_card one cycle with new_balance=15; approval_status=1 for 4 cycles starting 2 cycles after card_valid; done in the 4th cycle.
- Exact funds: selection=3, balance=12 -> approved, new_balance=0.
- Insufficient funds: selection=2, balance=7 -> decline_code=2 for 4 cycles, approval_status=0, no write_card, new_balance unchanged.
- Timeout: CARD_TIMEOUT=10, no card -> decline_code=1 ten cycles after entering WAIT_CARD. Repeat with card_valid on the timeout cycle -> CHECK is taken.
- Cancel/priority: cancel and card_valid in the same cycle -> decline_code=3. req with selection=0 -> busy stays 0.
- Async reset in APPROVE cycle 2 -> all outputs 0 immediately, before the next clock edge; no done. With REVENUE_LOG_EN, three approvals of selection 1 give txn_count=3 and revenue=15.
